// File: rtl/four_bit_full_adder.sv
// ---------------------------------------------------------------------------
// four_bit_full_adder
//
// Registered ripple-carry adder built from a chain of 1-bit full-adder
// cells. The combinational sum and carry are captured into output
// registers on every rising clock edge. There is no enable and no
// handshake, so the latency is exactly one cycle.
//
// Parameters:
//   WIDTH  operand/sum width in bits (>= 1), default 4
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   a      in   operand A, unsigned, WIDTH bits
//   b      in   operand B, unsigned, WIDTH bits
//   c_in   in   carry into bit 0
//   sum    out  registered (a + b + c_in) mod 2^WIDTH
//   c_out  out  registered carry out of the MSB
//   ovf    out  registered signed overflow (carry into MSB ^ carry out)
//   zero   out  registered flag, 1 when the registered sum is all zeros
// ---------------------------------------------------------------------------

// One bit of the ripple chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic p;

  assign p     = a ^ b;
  assign s     = p ^ c_in;
  assign c_out = (a & b) | (c_in & p);

endmodule

module four_bit_full_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  // carry_p0[i] is the carry into bit i; carry_p0[WIDTH] is the carry out.
  logic [WIDTH:0]   carry_p0;
  logic [WIDTH-1:0] sum_p0;
  logic             ovf_p0;
  logic             zero_p0;

  logic [WIDTH-1:0] sum_p1;
  logic             c_out_p1;
  logic             ovf_p1;
  logic             zero_p1;

  // ---- stage p0: combinational ripple chain -------------------------------
  assign carry_p0[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry_p0[i]),
      .s     (sum_p0[i]),
      .c_out (carry_p0[i+1])
    );
  end

  // Signed overflow happens exactly when the carry into the sign bit
  // differs from the carry out of it.
  assign ovf_p0  = carry_p0[WIDTH] ^ carry_p0[WIDTH-1];
  // Derived from the next-sum so it always matches the registered sum.
  assign zero_p0 = (sum_p0 == '0);

  // ---- stage p1: output registers -----------------------------------------
  // The reset state is a clean all-zero result, so zero reads as 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1   <= '0;
      c_out_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
      zero_p1  <= 1'b1;
    end else begin
      sum_p1   <= sum_p0;
      c_out_p1 <= carry_p0[WIDTH];
      ovf_p1   <= ovf_p0;
      zero_p1  <= zero_p0;
    end
  end

  assign sum   = sum_p1;
  assign c_out = c_out_p1;
  assign ovf   = ovf_p1;
  assign zero  = zero_p1;

endmodule

// File: tb/tb_four_bit_full_adder.sv
// ---------------------------------------------------------------------------
// Testbench for four_bit_full_adder (WIDTH = 4).
// Stimulus is applied on the falling edge; each applied cycle pushes the
// expected result onto a scoreboard queue, and a monitor pops and compares
// one entry 1 ns after every rising edge.
// Result packing for comparisons: {c_out, ovf, zero, sum[3:0]}.
// ---------------------------------------------------------------------------
module tb_four_bit_full_adder;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic [3:0] sum;
  logic       c_out;
  logic       ovf;
  logic       zero;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_t;

  typedef struct {
    string      tag;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] sum;
    logic       co;
    logic       ovf;
    logic       zero;
  } vec_t;

  sb_t  sb[$];
  vec_t tbl[$];

  four_bit_full_adder #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: plain integer addition; overflow from operand
  // and result sign bits rather than from internal carries.
  function automatic logic [6:0] model(input logic r, input logic [3:0] ma,
                                       input logic [3:0] mb, input logic mc);
    logic [4:0] full;
    logic       v;
    if (r) return {1'b0, 1'b0, 1'b1, 4'b0000};
    full = {1'b0, ma} + {1'b0, mb} + {4'b0000, mc};
    v    = (ma[3] == mb[3]) && (full[3] != ma[3]);
    return {full[4], v, (full[3:0] == 4'b0000), full[3:0]};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got {co,ovf,zero,sum}=%b required %b", name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus and record what must appear after the edge.
  task automatic drive(input string tag, input logic r, input logic [3:0] da,
                       input logic [3:0] db, input logic dc, input logic [6:0] exp);
    sb_t e;
    @(negedge clk);
    rst  = r;
    a    = da;
    b    = db;
    c_in = dc;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic add_vec(input string tag, input logic r, input logic [3:0] va,
                         input logic [3:0] vb, input logic vc, input logic [3:0] vs,
                         input logic vco, input logic vov, input logic vz);
    vec_t v;
    v.tag = tag; v.rst = r; v.a = va; v.b = vb; v.c = vc;
    v.sum = vs; v.co = vco; v.ovf = vov; v.zero = vz;
    tbl.push_back(v);
  endtask

  // Monitor: one scoreboard entry is consumed per rising edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, {c_out, ovf, zero, sum}, e.exp);
      end
    end
  end

  initial begin
    rst  = 1'b1;
    a    = 4'h0;
    b    = 4'h0;
    c_in = 1'b0;

    // Hand-derived vectors: rst, a, b, c_in -> sum, c_out, ovf, zero
    add_vec("reset0",      1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 1);
    add_vec("reset1",      1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 1);
    add_vec("6+3",         0, 4'h6, 4'h3, 0, 4'h9, 0, 1, 0);
    add_vec("15+1",        0, 4'hF, 4'h1, 0, 4'h0, 1, 0, 1);
    add_vec("15+0+1",      0, 4'hF, 4'h0, 1, 4'h0, 1, 0, 1);
    add_vec("15+15+1",     0, 4'hF, 4'hF, 1, 4'hF, 1, 0, 0);
    add_vec("7+1_ovf",     0, 4'h7, 4'h1, 0, 4'h8, 0, 1, 0);
    add_vec("8+8_ovf",     0, 4'h8, 4'h8, 0, 4'h0, 1, 1, 1);
    add_vec("15+1_noovf",  0, 4'hF, 4'h1, 0, 4'h0, 1, 0, 1);
    add_vec("0+0",         0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 1);
    add_vec("pre_rst_6+3", 0, 4'h6, 4'h3, 0, 4'h9, 0, 1, 0);
    add_vec("mid_rst",     1, 4'h6, 4'h3, 0, 4'h0, 0, 0, 1);
    add_vec("post_rst_2+2",0, 4'h2, 4'h2, 0, 4'h4, 0, 0, 0);
    add_vec("5+9+1",       0, 4'h5, 4'h9, 1, 4'hF, 0, 0, 0);

    // Table vectors are driven back to back, one per cycle.
    for (int i = 0; i < tbl.size(); i++)
      drive(tbl[i].tag, tbl[i].rst, tbl[i].a, tbl[i].b, tbl[i].c,
            {tbl[i].co, tbl[i].ovf, tbl[i].zero, tbl[i].sum});

    // Exhaustive sweep with c_in = 0.
    for (int j = 0; j < 16; j++)
      for (int i = 0; i < 16; i++)
        drive("exhaustive", 1'b0, 4'(i), 4'(j), 1'b0,
              model(1'b0, 4'(i), 4'(j), 1'b0));

    // Hold: operands changed between edges must not disturb the outputs.
    drive("hold_capture", 1'b0, 4'h6, 4'h3, 1'b0, {1'b0, 1'b1, 1'b0, 4'h9});
    @(posedge clk);
    #2;
    a    = 4'hF;
    b    = 4'hF;
    c_in = 1'b1;
    #1;
    check("hold_after_change", {c_out, ovf, zero, sum}, {1'b0, 1'b1, 1'b0, 4'h9});
    a    = 4'h0;
    b    = 4'h0;
    #1;
    check("hold_after_change2", {c_out, ovf, zero, sum}, {1'b0, 1'b1, 1'b0, 4'h9});

    // A few random back-to-back cycles including random resets.
    for (int k = 0; k < 20; k++) begin
      logic       rr;
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rc;
      rr = ($urandom_range(0, 7) == 0);
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      drive("random", rr, ra, rb, rc, model(rr, ra, rb, rc));
    end

    // Drain the scoreboard with a bounded wait.
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
